// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array feeder and collector: FSM encodings and array geometry defaults.
package pe_array_pkg;

  localparam int N_DEF          = 5;
  localparam int PORT_WIDTH_DEF = 8;
  localparam int LOC_W          = $clog2(N_DEF * N_DEF);

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/pe_array_feeder_if.sv
// Feeder bus: job control, weight/activation input streams, and array-facing preload/skew outputs.
interface pe_array_feeder_if
  import pe_array_pkg::*;
#(
  parameter int PORT_WIDTH = PORT_WIDTH_DEF,
  parameter int N          = N_DEF,
  parameter int COL_W      = 16,
  parameter int LW         = LOC_W
);
  logic                         start;
  logic [COL_W-1:0]             num_cols;
  logic                         w_valid;
  logic signed [PORT_WIDTH-1:0] w_data;
  logic                         w_ready;
  logic                         x_valid;
  logic [N*PORT_WIDTH-1:0]      x_data;
  logic                         x_ready;
  logic                         WorI;
  logic signed [PORT_WIDTH-1:0] weight_out;
  logic [LW-1:0]                weight_location;
  logic [N*PORT_WIDTH-1:0]      a_out;
  logic [N-1:0]                 a_valid;
  logic                         busy;
  logic                         done;

  modport master (
    output start, num_cols, w_valid, w_data, x_valid, x_data,
    input  w_ready, x_ready, WorI, weight_out, weight_location, a_out, a_valid, busy, done
  );

  modport slave (
    input  start, num_cols, w_valid, w_data, x_valid, x_data,
    output w_ready, x_ready, WorI, weight_out, weight_location, a_out, a_valid, busy, done
  );
endinterface

// File: rtl/pe_array_feeder_skew_delay_line.sv
// Fixed-depth shift register carrying data and valid together; output is the input DEPTH cycles earlier.
module skew_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic [W-1:0] out_dat,
  output logic         out_vld
);
  logic [W-1:0] dat_q [DEPTH];
  logic         vld_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        vld_q[i] <= 1'b0;
      end
    end else begin
      dat_q[0] <= in_dat;
      vld_q[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) begin
        dat_q[i] <= dat_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign out_dat = dat_q[DEPTH-1];
  assign out_vld = vld_q[DEPTH-1];
endmodule

// File: rtl/pe_array_feeder.sv
// Source side of the systolic array: preloads N*N weights, then injects column vectors with row-k skew of k cycles.
module pe_array_feeder
  import pe_array_pkg::*;
#(
  parameter int PORT_WIDTH = PORT_WIDTH_DEF,
  parameter int N          = N_DEF,
  parameter int COL_W      = 16
) (
  input logic clk,
  input logic rst,
  pe_array_feeder_if.slave bus
);
  localparam int LW = $clog2(N * N);
  localparam int DW = (N > 2) ? $clog2(N - 1) : 1;

  state_t                       state_q;
  logic [LW-1:0]                wcnt_q;
  logic [COL_W-1:0]             ncols_q;
  logic [COL_W-1:0]             ccnt_q;
  logic [DW-1:0]                dcnt_q;
  logic                         wori_q;
  logic signed [PORT_WIDTH-1:0] wout_q;
  logic [LW-1:0]                wloc_q;
  logic                         w_fire;
  logic                         x_fire;
  logic [N*PORT_WIDTH-1:0]      push_dat;
  logic [N*PORT_WIDTH-1:0]      a_dat;
  logic [N-1:0]                 a_vld;

  assign w_fire   = (state_q == ST_LOAD_W) && bus.w_valid;
  assign x_fire   = (state_q == ST_STREAM) && bus.x_valid;
  // Bubbles push zeros into every lane so the diagonal alignment never slips.
  assign push_dat = x_fire ? bus.x_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      ncols_q <= '0;
      ccnt_q  <= '0;
      dcnt_q  <= '0;
      wori_q  <= 1'b0;
      wout_q  <= '0;
      wloc_q  <= '0;
    end else begin
      wori_q <= w_fire;
      wout_q <= w_fire ? bus.w_data : '0;
      wloc_q <= w_fire ? wcnt_q : '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            ncols_q <= bus.num_cols;
            wcnt_q  <= '0;
            ccnt_q  <= '0;
            state_q <= ST_LOAD_W;
          end
        end
        ST_LOAD_W: begin
          if (w_fire) begin
            wcnt_q <= wcnt_q + LW'(1);
            if (wcnt_q == LW'(N * N - 1))
              state_q <= (ncols_q == '0) ? ST_DONE : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (x_fire) begin
            ccnt_q <= ccnt_q + COL_W'(1);
            if (ccnt_q == ncols_q - COL_W'(1)) begin
              dcnt_q  <= '0;
              state_q <= ST_DRAIN;
            end
          end
        end
        // N-1 cycles: the deepest lane's last element lands in its final register on the exit edge.
        ST_DRAIN: begin
          dcnt_q <= dcnt_q + DW'(1);
          if (dcnt_q == DW'(N - 2))
            state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    skew_delay_line #(
      .W    (PORT_WIDTH),
      .DEPTH(k + 1)
    ) u_dl (
      .clk    (clk),
      .rst    (rst),
      .in_dat (push_dat[k*PORT_WIDTH +: PORT_WIDTH]),
      .in_vld (x_fire),
      .out_dat(a_dat[k*PORT_WIDTH +: PORT_WIDTH]),
      .out_vld(a_vld[k])
    );
  end

  assign bus.w_ready         = (state_q == ST_LOAD_W);
  assign bus.x_ready         = (state_q == ST_STREAM);
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.done            = (state_q == ST_DONE);
  assign bus.WorI            = wori_q;
  assign bus.weight_out      = wout_q;
  assign bus.weight_location = wloc_q;
  assign bus.a_out           = a_dat;
  assign bus.a_valid         = a_vld;
endmodule
